// File: rtl/hack_pkg.sv
// Shared constants and the fetch-queue entry type for the instruction fetch slice.
package hack_pkg;

    localparam int ADDR_W  = 15;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous queue of fetched instructions; flush wins over push and pop.
module fetch_fifo
    import hack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Head comes straight from storage, so it keeps its last value once the queue drains.
    assign head = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the ROM address, absorbs its one-cycle read latency,
// queues fetched words and hands them to execute with a valid/accept handshake.
module instr_fetch
    import hack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rom_ready,
    output logic [ADDR_W:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_instruction,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_accept,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target
);

    localparam int             CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    localparam logic [0:0] WAIT_ROM = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              fetch_enable;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupied;
    logic [CNT_W:0]    room;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // The queue is only popped by a real handshake; a jump cycle belongs to the flush.
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_accept && !jump;
    assign push        = inflight && !jump;

    // Queue slots plus the in-flight word must never exceed DEPTH, so nothing is ever dropped.
    assign occupied = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign room     = DEPTH_C + {{CNT_W{1'b0}}, pop};

    // WAIT_ROM lets fetching start in the very cycle the ROM first reports ready.
    assign fetch_enable = (state == RUN) || rom_ready;
    assign issue        = rom_ready && fetch_enable && !jump && (occupied < room);

    assign rom_addr         = {1'b0, fetch_pc};
    assign push_entry.instr = rom_instruction;
    assign push_entry.pc    = inflight_pc;
    assign instr            = head.instr;
    assign instr_pc         = head.pc;

    // Leave WAIT_ROM once the ROM has finished loading; only a reset brings us back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_ROM;
        end else if (state == WAIT_ROM && rom_ready) begin
            state <= RUN;
        end
    end

    // Fetch pointer and the one-deep record of which address the ROM is currently reading.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (jump) begin
                fetch_pc <= jump_target;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 1'b1;
            end
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (jump),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a queue-based reference model.
module tb_instr_fetch;
    import hack_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic        rom_ready;
    logic [15:0] rom_addr;
    logic [15:0] rom_instruction;
    logic [15:0] instr;
    logic [14:0] instr_pc;
    logic        instr_valid;
    logic        instr_accept;
    logic        jump;
    logic [14:0] jump_target;

    int compare_count  = 0;
    int mismatch_count = 0;

    // Reference model state: where the next fetch goes, what the ROM is reading, what is queued.
    logic [14:0] m_fetch_pc;
    logic        m_inflight;
    logic [14:0] m_inflight_pc;
    logic [14:0] m_q[$];
    logic [14:0] next_pc;

    instr_fetch #(
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rom_ready       (rom_ready),
        .rom_addr        (rom_addr),
        .rom_instruction (rom_instruction),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_accept    (instr_accept),
        .jump            (jump),
        .jump_target     (jump_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: one-cycle read latency, content is the address XOR 0xA5A5.
    always @(posedge clk) rom_instruction <= rom_addr ^ 16'hA5A5;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_fetch_pc    = RESET_PC;
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_q.delete();
        next_pc       = RESET_PC;
    endtask

    // One clock of the fetch rules: pop, capture returning data, issue if a slot is guaranteed.
    task automatic modelStep(input logic ready, input logic accept, input logic jmp, input logic [14:0] target);
        bit take;
        bit iss;
        int credit;
        take   = (m_q.size() != 0) && accept && !jmp;
        credit = DEPTH - m_q.size() - int'(m_inflight) + int'(take);
        iss    = ready && !jmp && (credit > 0);
        if (jmp) begin
            m_q.delete();
        end else begin
            if (take) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back(m_inflight_pc);
        end
        if (m_q.size() > DEPTH) $display("[TB] model queue overflow at %0t", $time);
        if (iss) m_inflight_pc = m_fetch_pc;
        m_inflight = iss;
        if (jmp) m_fetch_pc = target;
        else if (iss) m_fetch_pc = m_fetch_pc + 15'd1;
    endtask

    task automatic checkCycle();
        checkOutput("instr_valid", instr_valid, m_q.size() != 0);
        checkOutput("rom_addr", rom_addr, {1'b0, m_fetch_pc});
        if (m_q.size() != 0) begin
            checkOutput("instr_pc", instr_pc, m_q[0]);
            checkOutput("instr", instr, {1'b0, m_q[0]} ^ 16'hA5A5);
        end
    endtask

    // Check the current cycle at the falling edge, then drive inputs for the next rising edge.
    task automatic applyStimulus(input logic ready, input logic accept, input logic jmp, input logic [14:0] target);
        @(negedge clk);
        checkCycle();
        rom_ready    = ready;
        instr_accept = accept;
        jump         = jmp;
        jump_target  = target;
        if (!reset_n) begin
            modelReset();
        end else begin
            if (instr_valid && accept && !jmp) begin
                checkOutput("stream_order", instr_pc, next_pc);
                next_pc = next_pc + 15'd1;
            end
            if (jmp) next_pc = target;
            modelStep(ready, accept, jmp, target);
        end
    endtask

    initial begin
        int first;
        reset_n      = 1'b0;
        rom_ready    = 1'b0;
        instr_accept = 1'b0;
        jump         = 1'b0;
        jump_target  = '0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        $display("[TB] idle with ROM not ready");
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 15'h0);

        $display("[TB] ROM ready, streaming");
        first = -1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 15'h0);
            if (first < 0 && instr_valid) first = k;
        end
        checkOutput("first_valid_latency", first, 2);

        $display("[TB] consumer stall");
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 15'h0);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 15'h0);

        $display("[TB] jump to 0x0100 with queue occupied");
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 15'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 15'h0100);
        first = -1;
        for (int k = 1; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 15'h0);
            if (first < 0 && instr_valid) first = k;
        end
        checkOutput("jump_latency", first, 3);

        $display("[TB] jump near top of address space");
        applyStimulus(1'b1, 1'b1, 1'b1, 15'h7FFE);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 15'h0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            logic        r;
            logic        a;
            logic        j;
            logic [14:0] t;
            r = ($urandom_range(0, 7) != 0);
            a = ($urandom_range(0, 3) != 0);
            j = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) == 0) ? 15'(15'h7FFC + $urandom_range(0, 3)) : 15'($urandom);
            applyStimulus(r, a, j, t);
        end

        $display("[TB] asynchronous reset mid-stream");
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 15'h0);
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        rom_ready = 1'b0;
        jump      = 1'b0;
        #1;
        checkOutput("async_reset_valid", instr_valid, 1'b0);
        checkOutput("async_reset_rom_addr", rom_addr, 16'h0000);
        modelReset();
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 15'h0);
        reset_n = 1'b1;
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 15'h0);
        first = -1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 15'h0);
            if (first < 0 && instr_valid) first = k;
        end
        checkOutput("restart_latency", first, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
